restoring_divider: RTL and testbench



---
 rtl/restoring_divider.sv | 128 ++++++++++++
 tb/tb_restoring_divider.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned radix-2 restoring divider with Start/Busy/Done handshake
// Optional build macro: DIVIDER_DIV0_FAST_EN (divide-by-zero completes in one cycle, skipping iteration)
module restoring_divider #(
    parameter int Operand_Width = 4,
    parameter int Product_Width = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [Product_Width-1:0] Dividend,
    input  logic [Operand_Width-1:0] Divisor,
    output logic                     Busy,
    output logic                     Done,
    output logic [Product_Width-1:0] Quotient,
    output logic [Operand_Width-1:0] Remainder,
    output logic                     Div_By_Zero
);

    localparam int CntW = $clog2(Product_Width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [CntW-1:0]          count;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after Product_Width iterations this register holds the quotient.
    logic [Product_Width-1:0] dq;
    logic [Operand_Width-1:0] dvs;
    logic [Operand_Width-1:0] dvd_low;
    logic [Operand_Width:0]   prem;

    logic [Operand_Width+1:0] shifted;
    logic [Operand_Width+1:0] trial;
    logic                     qbit;
    logic [Operand_Width:0]   next_prem;
    logic [Product_Width-1:0] next_dq;
    logic                     dvs_zero;

    // One iteration: shift in the next dividend bit, trial-subtract, keep or restore.
    // prem stays below the divisor, so its top bit is zero and trial's MSB is a clean sign.
    always_comb begin
        shifted   = {prem, dq[Product_Width-1]};
        trial     = shifted - {2'b00, dvs};
        qbit      = ~trial[Operand_Width+1];
        next_prem = qbit ? trial[Operand_Width:0] : shifted[Operand_Width:0];
        next_dq   = {dq[Product_Width-2:0], qbit};
        dvs_zero  = (dvs == '0);
    end

    // Control FSM and datapath registers; results only update on completion.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            count       <= '0;
            dq          <= '0;
            dvs         <= '0;
            dvd_low     <= '0;
            prem        <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            Div_By_Zero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        dq      <= Dividend;
                        dvs     <= Divisor;
                        dvd_low <= Dividend[Operand_Width-1:0];
                        prem    <= '0;
`ifdef DIVIDER_DIV0_FAST_EN
                        if (Divisor == '0) begin
                            state       <= DONE;
                            count       <= '0;
                            Busy        <= 1'b0;
                            Done        <= 1'b1;
                            Quotient    <= '1;
                            Remainder   <= Dividend[Operand_Width-1:0];
                            Div_By_Zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            count <= CntW'(Product_Width);
                            Busy  <= 1'b1;
                        end
`else
                        state <= RUN;
                        count <= CntW'(Product_Width);
                        Busy  <= 1'b1;
`endif
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                RUN: begin
                    dq    <= next_dq;
                    prem  <= next_prem;
                    count <= count - 1'b1;
                    if (count == CntW'(1)) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        if (dvs_zero) begin
                            Quotient    <= '1;
                            Remainder   <= dvd_low;
                            Div_By_Zero <= 1'b1;
                        end else begin
                            Quotient    <= next_dq;
                            Remainder   <= next_prem[Operand_Width-1:0];
                            Div_By_Zero <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider against an arithmetic reference model
module tb_restoring_divider;

    localparam int OW = 4;
    localparam int PW = 8;
`ifdef DIVIDER_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = PW + 1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0;
    logic [PW-1:0] Dividend = '0;
    logic [OW-1:0] Divisor = '0;
    logic          Busy;
    logic          Done;
    logic [PW-1:0] Quotient;
    logic [OW-1:0] Remainder;
    logic          Div_By_Zero;

    int passed = 0;
    int total  = 0;

    restoring_divider #(.Operand_Width(OW), .Product_Width(PW)) dut (
        .CLK(CLK),
        .RST(RST),
        .Start(Start),
        .Dividend(Dividend),
        .Divisor(Divisor),
        .Busy(Busy),
        .Done(Done),
        .Quotient(Quotient),
        .Remainder(Remainder),
        .Div_By_Zero(Div_By_Zero)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << PW) - 1;
            r = a % (1 << OW);
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // Issue one request from the current cycle and check the completion against the model.
    task automatic run_div(input string tag, input logic [PW-1:0] a, input logic [OW-1:0] b);
        int lat;
        int eq, er, ez, elat;
        model(int'(a), int'(b), eq, er, ez);
        elat = (b == 0) ? DIV0_LAT : PW + 1;
        Start = 1'b1;
        Dividend = a;
        Divisor = b;
        step();
        Start = 1'b0;
        lat = 1;
        while (Done !== 1'b1 && lat < 40) begin
            chk({tag, " busy"}, 32'(Busy), 32'd1);
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " busy at done"}, 32'(Busy), 32'd0);
        chk({tag, " quotient"}, 32'(Quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(Remainder), 32'(er));
        chk({tag, " div0"}, 32'(Div_By_Zero), 32'(ez));
        if (b != 0) begin
            chk({tag, " q*d+r"}, 32'(int'(Quotient) * int'(b) + int'(Remainder)), 32'(a));
            chk({tag, " r<d"}, 32'(int'(Remainder) < int'(b)), 32'd1);
        end
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset quotient", 32'(Quotient), 32'd0);
        chk("reset remainder", 32'(Remainder), 32'd0);
        chk("reset div0", 32'(Div_By_Zero), 32'd0);
        RST = 1'b0;
        step();

        // directed cases
        run_div("200/7", 8'd200, 4'd7);
        run_div("255/1", 8'd255, 4'd1);
        run_div("5/9", 8'd5, 4'd9);
        run_div("100/0", 8'd100, 4'd0);

        // back-to-back with an ignored mid-run Start
        Start = 1'b1; Dividend = 8'd60; Divisor = 4'd6;
        step();
        Start = 1'b0;
        step();
        step();
        Start = 1'b1; Dividend = 8'd99; Divisor = 4'd9;
        step();
        Start = 1'b0; Dividend = 8'd0; Divisor = 4'd0;
        chk("pipe busy T+4", 32'(Busy), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("pipe done T+9", 32'(Done), 32'd1);
        chk("pipe q T+9", 32'(Quotient), 32'd10);
        chk("pipe r T+9", 32'(Remainder), 32'd0);
        Start = 1'b1; Dividend = 8'd99; Divisor = 4'd9;
        step();
        Start = 1'b0;
        chk("pipe done T+10", 32'(Done), 32'd0);
        chk("pipe busy T+10", 32'(Busy), 32'd1);
        chk("pipe q hold T+10", 32'(Quotient), 32'd10);
        for (int i = 0; i < 8; i++) step();
        chk("pipe done T+18", 32'(Done), 32'd1);
        chk("pipe q T+18", 32'(Quotient), 32'd11);
        chk("pipe r T+18", 32'(Remainder), 32'd0);

        // reset mid-run
        Start = 1'b1; Dividend = 8'd200; Divisor = 4'd7;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort done", 32'(Done), 32'd0);
        chk("abort quotient", 32'(Quotient), 32'd0);
        chk("abort remainder", 32'(Remainder), 32'd0);
        chk("abort div0", 32'(Div_By_Zero), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("abort no done", 32'(Done), 32'd0);
            step();
        end

        // reset wins over Start
        RST = 1'b1; Start = 1'b1; Dividend = 8'd200; Divisor = 4'd7;
        step();
        RST = 1'b0; Start = 1'b0;
        chk("rst+start busy", 32'(Busy), 32'd0);
        step();
        chk("rst+start busy later", 32'(Busy), 32'd0);
        chk("rst+start done", 32'(Done), 32'd0);

        // exhaustive nonzero sweep, issued back-to-back from each Done cycle
        for (int d = 1; d < (1 << OW); d++) begin
            for (int n = 0; n < (1 << PW); n++) begin
                run_div("sweep", PW'(n), OW'(d));
            end
        end

        // random operands including divide-by-zero
        for (int i = 0; i < 200; i++) begin
            run_div("random", PW'($urandom_range(0, (1 << PW) - 1)), OW'($urandom_range(0, (1 << OW) - 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
